// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
// Shares one single-port synchronous memory between an instruction-fetch
// requester (read only) and a data requester (load/store). At most one
// access is issued per cycle. Grants are combinational in the request
// cycle. A registered owner records who was granted, so the matching
// rvalid pulses exactly one cycle later, when mem_rdata is valid.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : on conflict the requester not granted last wins
//   undefined : on conflict the data requester always wins
//
// Ports
//   clk, rst                          clock, asynchronous active-high reset
//   if_req/if_addr                    fetch request and address
//   if_gnt/if_rvalid/if_rdata         fetch grant and read response
//   d_req/d_we/d_addr/d_wdata/d_wstrb data request and payload
//   d_gnt/d_rvalid/d_rdata            data grant and response (store ack has rdata=0)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_wstrb  memory command
//   mem_rdata                         memory read data, valid the cycle after mem_en
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [STRB_W-1:0] d_wstrb,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    owner_t owner_reg, owner_next;
    // Distinguishes a data load (return mem_rdata) from a store ack (return 0).
    logic   d_load_reg, d_load_next;

    logic   grant_fetch;
    logic   grant_data;
    logic   fetch_wins_conflict;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = fetch was granted last, 0 = data was granted last (reset value).
    logic last_fetch_reg, last_fetch_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_fetch_reg <= 1'b0;
        end else begin
            last_fetch_reg <= last_fetch_next;
        end
    end

    assign fetch_wins_conflict = ~last_fetch_reg;

    always_comb begin
        last_fetch_next = last_fetch_reg;
        if (grant_fetch) begin
            last_fetch_next = 1'b1;
        end else if (grant_data) begin
            last_fetch_next = 1'b0;
        end
    end
`else
    assign fetch_wins_conflict = 1'b0;
`endif

    // Owner state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_reg  <= OWN_NONE;
            d_load_reg <= 1'b0;
        end else begin
            owner_reg  <= owner_next;
            d_load_reg <= d_load_next;
        end
    end

    // Grant, memory command and next owner. Everything is forced idle while
    // rst is high so no access is issued and no grant is seen during reset.
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        owner_next  = OWN_NONE;
        d_load_next = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        if (!rst) begin
            if (if_req && d_req) begin
                grant_fetch = fetch_wins_conflict;
                grant_data  = ~fetch_wins_conflict;
            end else begin
                grant_fetch = if_req;
                grant_data  = d_req;
            end
        end

        if (grant_fetch) begin
            owner_next = OWN_FETCH;
            mem_addr   = if_addr;
        end else if (grant_data) begin
            owner_next  = OWN_DATA;
            d_load_next = ~d_we;
            mem_addr    = d_addr;
            mem_wdata   = d_wdata;
        end
    end

    assign if_gnt = grant_fetch;
    assign d_gnt  = grant_data;
    assign mem_en = grant_fetch | grant_data;
    assign mem_we = grant_data & d_we;

    // Byte enables only reach memory on a granted store.
    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_wstrb
            assign mem_wstrb[gi] = mem_we & d_wstrb[gi];
        end
    endgenerate

    // Responses: one cycle after grant, steered by the registered owner.
    assign if_rvalid = (owner_reg == OWN_FETCH);
    assign d_rvalid  = (owner_reg == OWN_DATA);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && d_load_reg) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    // Inputs change on the falling edge; outputs are sampled 1 ns later,
    // well away from the rising edge.
    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = 32'h0000_0ABC;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'h0000_0DEF;
        d_wdata   = 32'h5555_AAAA;
        d_wstrb   = 4'hF;
        mem_rdata = 32'h0BAD_0BAD;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_if;
        @(negedge clk);
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        total_cnt++;
        if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid} !== 6'b0) begin
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid});
        end else pass_cnt++;
        total_cnt++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            $display("FAIL reset_mem: addr %h wdata %h wstrb %h expected all 0", mem_addr, mem_wdata, mem_wstrb);
        end else pass_cnt++;
        total_cnt++;
        if ({if_rdata, d_rdata} !== '0) begin
            $display("FAIL reset_rdata: if_rdata %h d_rdata %h expected 0", if_rdata, d_rdata);
        end else pass_cnt++;
        // Release with both requests still asserted: must arbitrate at once.
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_if = RR;  // round robin: last=DATA after reset, so fetch wins
        total_cnt++;
        if ({mem_en, if_gnt, d_gnt} !== {1'b1, exp_if, ~exp_if}) begin
            $display("FAIL release_grant: en/if_gnt/d_gnt %b expected %b", {mem_en, if_gnt, d_gnt}, {1'b1, exp_if, ~exp_if});
        end else pass_cnt++;
        $display("reset: checked outputs during reset and first grant after release");
    endtask

    task automatic test_fetch();
        do_reset();
        @(negedge clk);
        idle_inputs();
        if_req = 1'b1; if_addr = 32'h40;
        d_wstrb = 4'hF; d_we = 1'b1;  // data side idle, its payload must not leak
        #1;
        total_cnt++;
        if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010) begin
            $display("FAIL fetch_gnt: gnt/en/we %b expected 1010", {if_gnt, d_gnt, mem_en, mem_we});
        end else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 32'h40 || mem_wstrb !== 4'h0) begin
            $display("FAIL fetch_cmd: addr %h wstrb %h expected 00000040 0", mem_addr, mem_wstrb);
        end else pass_cnt++;
        @(negedge clk);
        idle_inputs();
        mem_rdata = 32'h00500093;
        #1;
        total_cnt++;
        if ({if_rvalid, d_rvalid} !== 2'b10 || if_rdata !== 32'h00500093) begin
            $display("FAIL fetch_resp: rvalid %b rdata %h expected 10 00500093", {if_rvalid, d_rvalid}, if_rdata);
        end else pass_cnt++;
        total_cnt++;
        if (mem_en !== 1'b0 || mem_addr !== '0) begin
            $display("FAIL idle_cmd: en %b addr %h expected 0 0", mem_en, mem_addr);
        end else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++;
        if ({if_rvalid, d_rvalid} !== 2'b00 || if_rdata !== '0) begin
            $display("FAIL fetch_single_pulse: rvalid %b rdata %h expected 00 0", {if_rvalid, d_rvalid}, if_rdata);
        end else pass_cnt++;
        $display("fetch: addr 0x40 -> rdata 0x00500093");
    endtask

    task automatic test_store();
        @(negedge clk);
        idle_inputs();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        #1;
        total_cnt++;
        if ({d_gnt, if_gnt, mem_en, mem_we} !== 4'b1011 || mem_wstrb !== 4'hF) begin
            $display("FAIL store_cmd: gnt/en/we %b wstrb %h expected 1011 f", {d_gnt, if_gnt, mem_en, mem_we}, mem_wstrb);
        end else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
            $display("FAIL store_payload: addr %h wdata %h expected 00000100 deadbeef", mem_addr, mem_wdata);
        end else pass_cnt++;
        @(negedge clk);
        idle_inputs();
        mem_rdata = 32'hCAFEF00D;
        #1;
        total_cnt++;
        if ({if_rvalid, d_rvalid} !== 2'b01 || d_rdata !== '0) begin
            $display("FAIL store_ack: rvalid %b d_rdata %h expected 01 0", {if_rvalid, d_rvalid}, d_rdata);
        end else pass_cnt++;
        // Load with stray strobes: strobes must be masked, load returns data.
        @(negedge clk);
        idle_inputs();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104; d_wstrb = 4'h3;
        #1;
        total_cnt++;
        if (mem_we !== 1'b0 || mem_wstrb !== 4'h0 || mem_addr !== 32'h104) begin
            $display("FAIL load_cmd: we %b wstrb %h addr %h expected 0 0 00000104", mem_we, mem_wstrb, mem_addr);
        end else pass_cnt++;
        @(negedge clk);
        idle_inputs();
        mem_rdata = 32'h12345678;
        #1;
        total_cnt++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678 || if_rdata !== '0) begin
            $display("FAIL load_resp: d_rvalid %b d_rdata %h if_rdata %h expected 1 12345678 0", d_rvalid, d_rdata, if_rdata);
        end else pass_cnt++;
        $display("store: 0xDEADBEEF -> 0x100 acked, load 0x104 -> 0x12345678");
    endtask

    task automatic test_conflict();
        logic exp_f;
        logic prev_f;
        do_reset();
        prev_f = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            idle_inputs();
            mem_rdata = 32'hA000_0000 + 32'(k);
            if (k < 4) begin
                if_req = 1'b1; if_addr = 32'h40;
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
            end
            #1;
            if (k > 0) begin
                total_cnt++;
                if ({if_rvalid, d_rvalid} !== {prev_f, ~prev_f} ||
                    if_rdata !== (prev_f ? mem_rdata : 32'h0) ||
                    d_rdata !== (prev_f ? 32'h0 : mem_rdata)) begin
                    $display("FAIL conflict_resp%0d: rvalid %b if_rdata %h d_rdata %h expected %b", k,
                             {if_rvalid, d_rvalid}, if_rdata, d_rdata, {prev_f, ~prev_f});
                end else pass_cnt++;
            end
            if (k < 4) begin
                exp_f = RR && (k % 2 == 0);
                total_cnt++;
                if ({if_gnt, d_gnt} !== {exp_f, ~exp_f} || mem_addr !== (exp_f ? 32'h40 : 32'h300)) begin
                    $display("FAIL conflict_gnt%0d: if_gnt/d_gnt %b addr %h expected %b %h", k,
                             {if_gnt, d_gnt}, mem_addr, {exp_f, ~exp_f}, (exp_f ? 32'h40 : 32'h300));
                end else pass_cnt++;
                $display("conflict cycle %0d: if_gnt=%b d_gnt=%b", k, if_gnt, d_gnt);
                prev_f = exp_f;
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        idle_inputs();
        if_req = 1'b1; if_addr = 32'h80;
        #1;
        total_cnt++;
        if (if_gnt !== 1'b1 || mem_addr !== 32'h80) begin
            $display("FAIL b2b_fetch_gnt: if_gnt %b addr %h expected 1 00000080", if_gnt, mem_addr);
        end else pass_cnt++;
        @(negedge clk);
        idle_inputs();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        mem_rdata = 32'h0000_0013;
        #1;
        total_cnt++;
        if ({if_rvalid, d_rvalid, d_gnt} !== 3'b101 || if_rdata !== 32'h13 || mem_addr !== 32'h200) begin
            $display("FAIL b2b_n1: rvalid/d_gnt %b if_rdata %h addr %h expected 101 00000013 00000200",
                     {if_rvalid, d_rvalid, d_gnt}, if_rdata, mem_addr);
        end else pass_cnt++;
        @(negedge clk);
        idle_inputs();
        mem_rdata = 32'h1122_3344;
        #1;
        total_cnt++;
        if ({if_rvalid, d_rvalid} !== 2'b01 || d_rdata !== 32'h11223344 || if_rdata !== '0) begin
            $display("FAIL b2b_n2: rvalid %b d_rdata %h if_rdata %h expected 01 11223344 0",
                     {if_rvalid, d_rvalid}, d_rdata, if_rdata);
        end else pass_cnt++;
        $display("back_to_back: fetch 0x80 then load 0x200");
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        idle_inputs();
        if_req = 1'b1; if_addr = 32'h44;
        #1;
        total_cnt++;
        if (if_gnt !== 1'b1) begin
            $display("FAIL midrst_gnt: if_gnt %b expected 1", if_gnt);
        end else pass_cnt++;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        mem_rdata = 32'h7777_7777;
        #1;
        total_cnt++;
        if ({if_rvalid, d_rvalid} !== 2'b00 || if_rdata !== '0) begin
            $display("FAIL midrst_discard: rvalid %b if_rdata %h expected 00 0", {if_rvalid, d_rvalid}, if_rdata);
        end else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            total_cnt++;
            if ({if_rvalid, d_rvalid, mem_en} !== 3'b000) begin
                $display("FAIL midrst_after%0d: rvalid/en %b expected 000", k, {if_rvalid, d_rvalid, mem_en});
            end else pass_cnt++;
        end
        $display("reset_mid_op: pending fetch response discarded");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_store();
        test_conflict();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
